// File: rtl/de_sync_pkg.sv
// Shared constants and types for the framing-link receive path.
package de_sync_pkg;

  localparam logic [31:0] SYNC_WORD_DEF   = 32'h1ACF_FC1D;
  localparam logic [31:0] PAD_WORD_DEF    = 32'h0707_0707;
  localparam int          FRAME_WORDS_DEF = 64;
  localparam int          MISS_LIMIT_DEF  = 3;
  localparam int          WORD_BYTES      = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    HEADER = 2'd2
  } state_e;

  // Counter width that stays legal for a depth of 1.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/de_sync_word2byte.sv
// 32->8 MSB-first serialiser; one word buffer, refills on the edge its last byte leaves.
module de_sync_word2byte
  import de_sync_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i
);

  logic [31:0] buf_q, buf_d;
  logic [1:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic        last_q, last_d;
  logic        take, fin, load;

  assign take = vld_q & out_ready_i;
  assign fin  = take & (idx_q == 2'(WORD_BYTES - 1));
  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign in_ready_o = rst_n_i & (~vld_q | fin);
  assign load = in_valid_i & in_ready_o;

  always_comb begin
    buf_d  = buf_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load) begin
      buf_d  = in_data_i;
      idx_d  = '0;
      vld_d  = 1'b1;
      last_d = in_last_i;
    end else if (fin) begin
      vld_d  = 1'b0;
      idx_d  = '0;
      last_d = 1'b0;
    end else if (take) begin
      buf_d  = {buf_q[23:0], 8'h00};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign out_data_o  = buf_q[31:24];
  assign out_valid_o = vld_q;
  assign out_last_o  = vld_q & last_q & (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/de_sync.sv
// Frame de-synchroniser: hunts for the sync header, strips headers/pads, serialises payload.
module de_sync
  import de_sync_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [31:0] PAD_WORD    = PAD_WORD_DEF,
  parameter int          FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int          MISS_LIMIT  = MISS_LIMIT_DEF
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic [31:0] s_axis_input_tdata,
  input  logic        s_axis_input_tvalid,
  output logic        s_axis_input_tready,
  output logic [7:0]  m_axis_output_tdata,
  output logic        m_axis_output_tvalid,
  output logic        m_axis_output_tlast,
  input  logic        m_axis_output_tready,
  output logic        locked,
  output logic        sync_err
);

  localparam int WCW = cnt_w(FRAME_WORDS);
  localparam int MCW = $clog2(MISS_LIMIT + 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [MCW-1:0] miss_q, miss_d;
  logic           err_q, err_d;
  logic           s_rdy, acc, w_last, pay_vld;

  assign acc     = s_axis_input_tvalid & s_rdy;
  assign w_last  = (wcnt_q == WCW'(FRAME_WORDS - 1));
  assign pay_vld = s_axis_input_tvalid & (state_q == DATA);

  always_ff @(posedge core_clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      wcnt_q  <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (acc) begin
      unique case (state_q)
        HUNT: begin
          if (s_axis_input_tdata == SYNC_WORD) begin
            state_d = DATA;
            wcnt_d  = '0;
            miss_d  = '0;
          end
        end
        DATA: begin
          if (w_last) begin
            wcnt_d  = '0;
            state_d = HEADER;
          end else begin
            wcnt_d  = wcnt_q + WCW'(1);
          end
        end
        HEADER: begin
          if (s_axis_input_tdata == SYNC_WORD) begin
            miss_d  = '0;
            state_d = DATA;
          end else if (s_axis_input_tdata != PAD_WORD) begin
            err_d = 1'b1;
            // Flywheel through isolated bad headers; drop lock once misses run out.
            if (int'(miss_q) + 1 >= MISS_LIMIT) begin
              miss_d  = MCW'(MISS_LIMIT);
              state_d = HUNT;
            end else begin
              miss_d  = miss_q + MCW'(1);
              state_d = DATA;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked              = (state_q != HUNT);
    sync_err            = err_q;
    s_axis_input_tready = s_rdy;
  end

  de_sync_word2byte u_w2b (
    .clk_i       (core_clk),
    .rst_n_i     (rst),
    .in_data_i   (s_axis_input_tdata),
    .in_valid_i  (pay_vld),
    .in_last_i   (w_last),
    .in_ready_o  (s_rdy),
    .out_data_o  (m_axis_output_tdata),
    .out_valid_o (m_axis_output_tvalid),
    .out_last_o  (m_axis_output_tlast),
    .out_ready_i (m_axis_output_tready)
  );

endmodule

// File: tb/tb_de_sync.sv
// Directed bench for de_sync: header table, hunt, backpressure and mid-frame reset.
module tb_de_sync;

  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;
  localparam logic [31:0] PAD  = 32'h0707_0707;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
  localparam int          FW   = 64;

  logic        core_clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        locked, sync_err;
  bit          bp_en = 1'b0;

  int checks = 0, errors = 0;
  int err_cnt = 0, stall_bad = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;

  de_sync dut (
    .core_clk             (core_clk),
    .rst                  (rst),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tready  (s_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tlast  (m_tlast),
    .m_axis_output_tready (m_tready),
    .locked               (locked),
    .sync_err             (sync_err)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) begin
    #1;
    m_tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Byte capture, sync_err pulse count and stall-stability watch, all at the falling edge.
  always @(negedge core_clk) begin
    if (rst) begin
      if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
      if (sync_err) err_cnt++;
      if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stall_bad++;
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
    end else begin
      pv = 1'b0; pr = 1'b0;
    end
  end

  typedef struct {
    int          npad;
    logic [31:0] hdr;
    int          seed;
    int          exp_err;
    logic        exp_lock;
    int          exp_bytes;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [31:0] payload(input int seed, input int k);
    logic [7:0] b;
    if (seed == 0 && k == 0) return 32'h1122_3344;
    b = 8'(k + seed * 64);
    return {4{b}};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    s_tdata = w; s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 2000) begin
      @(negedge core_clk); #1; n++;
    end
    if (!s_tready) begin
      checks++; errors++;
      $display("FAIL send_timeout got=ready0 exp=ready1");
    end
    @(negedge core_clk);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge core_clk);
    while (m_tvalid && n < 5000) begin
      @(negedge core_clk); n++;
    end
    if (m_tvalid) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=valid1 exp=valid0");
    end
    @(negedge core_clk);
  endtask

  task automatic exp_frame(input int seed);
    logic [31:0] w;
    for (int k = 0; k < FW; k++) begin
      w = payload(seed, k);
      for (int b = 0; b < 4; b++)
        exp_q.push_back({(k == FW - 1 && b == 3), w[31 - 8*b -: 8]});
    end
  endtask

  task automatic chk_bytes(input string name);
    int bad = -1;
    chk({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_data idx=%0d got=%0h exp=%0h", name, bad, rx_q[bad], exp_q[bad]);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic junk(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (w == SYNC) w = w ^ 32'h1;
      send(w);
    end
  endtask

  initial begin
    int e0;
    tbl[0]  = '{0, SYNC, 0, 0, 1'b1, 256};
    tbl[1]  = '{5, SYNC, 1, 0, 1'b1, 256};
    tbl[2]  = '{0, BAD,  2, 1, 1'b1, 256};
    tbl[3]  = '{0, BAD,  3, 1, 1'b1, 256};
    tbl[4]  = '{0, BAD,  4, 1, 1'b0, 0};
    tbl[5]  = '{0, SYNC, 5, 0, 1'b1, 256};
    tbl[6]  = '{2, BAD,  6, 1, 1'b1, 256};
    tbl[7]  = '{0, SYNC, 7, 0, 1'b1, 256};
    tbl[8]  = '{1, BAD,  8, 1, 1'b1, 256};
    tbl[9]  = '{0, BAD,  9, 1, 1'b1, 256};
    tbl[10] = '{3, SYNC, 10, 0, 1'b1, 256};

    #3;
    chk("reset_outs", {s_tready, m_tvalid, m_tlast, m_tdata, locked, sync_err}, '0);
    @(negedge core_clk); rst = 1'b1; #1;
    chk("post_reset_ready", {s_tready, m_tvalid, locked}, 3'b100);

    junk(10);
    drain();
    chk("hunt_locked", locked, 1'b0);
    chk("hunt_bytes", 64'(rx_q.size()), 0);

    foreach (tbl[i]) begin
      @(negedge core_clk); #1;
      e0 = err_cnt;
      for (int p = 0; p < tbl[i].npad; p++) send(PAD);
      send(tbl[i].hdr); #1;
      chk($sformatf("v%0d_locked", i), locked, tbl[i].exp_lock);
      for (int k = 0; k < FW; k++) begin
        send(payload(tbl[i].seed, k));
        if (i == 0 && k == 0) begin
          #1; chk("first_byte_lat1", {m_tvalid, m_tdata}, 9'h111);
        end
      end
      drain();
      chk($sformatf("v%0d_sync_err", i), 64'(err_cnt - e0), 64'(tbl[i].exp_err));
      if (tbl[i].exp_bytes > 0) exp_frame(tbl[i].seed);
      chk_bytes($sformatf("v%0d_bytes", i));
    end

    bp_en = 1'b1;
    e0 = err_cnt;
    for (int f = 0; f < 4; f++) begin
      send(SYNC);
      for (int k = 0; k < FW; k++) send(payload(20 + f, k));
      exp_frame(20 + f);
    end
    drain();
    bp_en = 1'b0;
    chk_bytes("bp_bytes");
    chk("bp_stall_stable", 64'(stall_bad), 0);
    chk("bp_sync_err", 64'(err_cnt - e0), 0);

    send(SYNC);
    for (int k = 0; k < 20; k++) send(payload(30, k));
    #2; rst = 1'b0; #1;
    chk("midreset_outs", {s_tready, m_tvalid, m_tlast, m_tdata, locked, sync_err}, '0);
    repeat (3) @(negedge core_clk);
    rst = 1'b1;
    rx_q.delete(); exp_q.delete();
    for (int k = 20; k < FW; k++) send(payload(30, k));
    drain();
    chk("after_reset_hunt_locked", locked, 1'b0);
    chk("after_reset_hunt_bytes", 64'(rx_q.size()), 0);
    send(SYNC); #1;
    chk("relock", locked, 1'b1);
    for (int k = 0; k < FW; k++) send(payload(31, k));
    drain();
    exp_frame(31);
    chk_bytes("relock_bytes");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
